// File: rtl/rs5_plic_pkg.sv
// Shared constants and types for the RS5 platform-level interrupt controller.
package rs5_plic_pkg;

    localparam int PRIO_W = 3;
    localparam int ID_W   = 5;

    localparam logic [23:0] PRIO_BASE     = 24'h000000;
    localparam logic [23:0] PENDING_OFF   = 24'h001000;
    localparam logic [23:0] ENABLE_OFF    = 24'h002000;
    localparam logic [23:0] THRESHOLD_OFF = 24'h200000;
    localparam logic [23:0] CLAIM_OFF     = 24'h200004;

    typedef logic [PRIO_W-1:0] prio_t;
    typedef logic [ID_W-1:0]   id_t;

endpackage

// File: rtl/rs5_plic_arbiter.sv
// Combinational arbiter: highest priority above threshold wins, ties go to the lowest ID.
module rs5_plic_arbiter
    import rs5_plic_pkg::*;
#(
    parameter int i_cnt = 1
) (
    input  logic [i_cnt:1]             cand_i,
    input  logic [i_cnt:1][PRIO_W-1:0] prio_i,
    input  prio_t                      threshold_i,
    output id_t                        best_id_o
);

    prio_t best_prio;

    // Strict '>' keeps the earlier (lower) ID on equal priority; any eligible
    // priority is above the threshold and therefore above the initial zero.
    always_comb begin
        best_id_o = '0;
        best_prio = '0;
        for (int n = 1; n <= i_cnt; n++) begin
            if (cand_i[n] && (prio_i[n] > threshold_i) && (prio_i[n] > best_prio)) begin
                best_id_o = id_t'(n);
                best_prio = prio_i[n];
            end
        end
    end

endmodule

// File: rtl/rs5_plic.sv
// PLIC top: register file, level gateways, claim/complete tracking and the core interrupt line.
module rs5_plic
    import rs5_plic_pkg::*;
#(
    parameter int i_cnt = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic [3:0]       we_i,
    input  logic [23:0]      addr_i,
    input  logic [31:0]      data_i,
    output logic [31:0]      data_o,
    input  logic [i_cnt:1]   irq_i,
    input  logic             iack_i,
    output logic [i_cnt:1]   iack_o,
    output logic             irq_o
);

    logic [i_cnt:1][PRIO_W-1:0] prio_q, prio_d;
    logic [i_cnt:1]             pending_q, pending_d;
    logic [i_cnt:1]             enable_q, enable_d;
    logic [i_cnt:1]             in_flight_q, in_flight_d;
    logic [i_cnt:1]             iack_q, iack_d;
    prio_t                      threshold_q, threshold_d;
    id_t                        claim_q, claim_d;
    logic [31:0]                data_q, data_d;
    logic                       irq_q, irq_d;

    logic        wr_en, rd_en, prio_hit;
    logic [23:0] word_addr;
    id_t         prio_idx;
    id_t         best_id;
    logic [31:0] rd_data;

    assign wr_en     = en_i && (we_i != 4'h0);
    assign rd_en     = en_i && (we_i == 4'h0);
    assign word_addr = addr_i & 24'hFFFFFC;
    assign prio_idx  = word_addr[6:2];
    assign prio_hit  = (word_addr[23:7] == 17'h0) && (prio_idx != '0) && (int'(prio_idx) <= i_cnt);

    rs5_plic_arbiter #(.i_cnt(i_cnt)) u_arbiter (
        .cand_i      (pending_q & enable_q),
        .prio_i      (prio_q),
        .threshold_i (threshold_q),
        .best_id_o   (best_id)
    );

    always_comb begin
        rd_data = '0;
        if (prio_hit) begin
            for (int n = 1; n <= i_cnt; n++) begin
                if (prio_idx == id_t'(n)) rd_data[PRIO_W-1:0] = prio_q[n];
            end
        end else begin
            case (word_addr)
                PENDING_OFF:   for (int n = 1; n <= i_cnt; n++) rd_data[n] = pending_q[n];
                ENABLE_OFF:    for (int n = 1; n <= i_cnt; n++) rd_data[n] = enable_q[n];
                THRESHOLD_OFF: rd_data[PRIO_W-1:0] = threshold_q;
                CLAIM_OFF:     rd_data[ID_W-1:0]   = claim_q;
                default:       rd_data = '0;
            endcase
        end
    end

    always_comb begin
        prio_d      = prio_q;
        enable_d    = enable_q;
        threshold_d = threshold_q;
        in_flight_d = in_flight_q;
        claim_d     = claim_q;
        data_d      = rd_en ? rd_data : data_q;
        iack_d      = '0;

        if (wr_en) begin
            if (prio_hit) begin
                for (int n = 1; n <= i_cnt; n++) begin
                    if (prio_idx == id_t'(n)) prio_d[n] = data_i[PRIO_W-1:0];
                end
            end else begin
                case (word_addr)
                    ENABLE_OFF:    enable_d    = data_i[i_cnt:1];
                    THRESHOLD_OFF: threshold_d = data_i[PRIO_W-1:0];
                    CLAIM_OFF: begin
                        for (int n = 1; n <= i_cnt; n++) begin
                            if (data_i == 32'(n)) in_flight_d[n] = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Gateways block re-triggering while a source is pending or being serviced.
        pending_d = pending_q | (irq_i & ~in_flight_q);

        // Claim is applied last so it overrides a same-cycle gateway set.
        if (iack_i) begin
            claim_d = best_id;
            for (int n = 1; n <= i_cnt; n++) begin
                if (best_id == id_t'(n)) begin
                    pending_d[n]   = 1'b0;
                    in_flight_d[n] = 1'b1;
                    iack_d[n]      = 1'b1;
                end
            end
        end

        irq_d = (best_id != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q      <= '0;
            pending_q   <= '0;
            enable_q    <= '0;
            in_flight_q <= '0;
            iack_q      <= '0;
            threshold_q <= '0;
            claim_q     <= '0;
            data_q      <= '0;
            irq_q       <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            in_flight_q <= in_flight_d;
            iack_q      <= iack_d;
            threshold_q <= threshold_d;
            claim_q     <= claim_d;
            data_q      <= data_d;
            irq_q       <= irq_d;
        end
    end

    assign data_o = data_q;
    assign iack_o = iack_q;
    assign irq_o  = irq_q;

endmodule

// File: tb/tb_rs5_plic.sv
// Self-checking bench for rs5_plic: vector table, directed corner sequences and a random run against a register-level model.
module tb_rs5_plic;

    localparam int N = 4;

    logic          clk;
    logic          reset_n;
    logic          en_i;
    logic [3:0]    we_i;
    logic [23:0]   addr_i;
    logic [31:0]   data_i;
    logic [31:0]   data_o;
    logic [N:1]    irq_i;
    logic          iack_i;
    logic [N:1]    iack_o;
    logic          irq_o;

    int n_pass  = 0;
    int n_total = 0;

    // Model of the architectural state, indexed by source ID.
    int          m_prio [N+1];
    logic [N:1]  m_pend, m_en, m_infl, m_iack;
    int          m_thr;
    logic [31:0] m_claim, m_data;
    logic        m_irq;

    rs5_plic #(.i_cnt(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (en_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .irq_i   (irq_i),
        .iack_i  (iack_i),
        .iack_o  (iack_o),
        .irq_o   (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic int model_best();
        int maxp = 0;
        for (int id = 1; id <= N; id++)
            if (m_pend[id] && m_en[id] && m_prio[id] > m_thr && m_prio[id] > maxp) maxp = m_prio[id];
        if (maxp == 0) return 0;
        for (int id = 1; id <= N; id++)
            if (m_pend[id] && m_en[id] && m_prio[id] == maxp) return id;
        return 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [23:0] addr);
        logic [23:0] a;
        logic [31:0] r;
        int idx;
        a = addr & 24'hFFFFFC;
        r = '0;
        if (a < 24'h80) begin
            idx = int'(a[6:2]);
            if (idx >= 1 && idx <= N) r = 32'(m_prio[idx]);
        end else begin
            case (a)
                24'h001000: r[N:1] = m_pend;
                24'h002000: r[N:1] = m_en;
                24'h200000: r = 32'(m_thr);
                24'h200004: r = m_claim;
                default:    r = '0;
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int id = 0; id <= N; id++) m_prio[id] = 0;
        m_pend = '0; m_en = '0; m_infl = '0; m_iack = '0;
        m_thr = 0; m_claim = '0; m_data = '0; m_irq = 1'b0;
    endtask

    // One clock: advance the model from the applied inputs, then compare all outputs.
    task automatic step();
        int          best, idx;
        int          p [N+1];
        logic [N:1]  pe, en, inf, ia;
        int          thr;
        logic [31:0] cl, dat;
        logic [23:0] a;
        best = model_best();
        p = m_prio; pe = m_pend; en = m_en; inf = m_infl; thr = m_thr; cl = m_claim; dat = m_data;
        if (en_i && we_i == 4'h0) dat = model_read(addr_i);
        if (en_i && we_i != 4'h0) begin
            a = addr_i & 24'hFFFFFC;
            idx = int'(a[6:2]);
            if (a < 24'h80) begin
                if (idx >= 1 && idx <= N) p[idx] = int'(data_i[2:0]);
            end else if (a == 24'h002000) en = data_i[N:1];
            else if (a == 24'h200000) thr = int'(data_i[2:0]);
            else if (a == 24'h200004) begin
                for (int id = 1; id <= N; id++) if (data_i == 32'(id) && m_infl[id]) inf[id] = 1'b0;
            end
        end
        for (int id = 1; id <= N; id++) if (irq_i[id] && !m_infl[id] && !m_pend[id]) pe[id] = 1'b1;
        ia = '0;
        if (iack_i) begin
            cl = 32'(best);
            if (best != 0) begin
                pe[best] = 1'b0; inf[best] = 1'b1; ia[best] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        m_irq = (best != 0);
        m_prio = p; m_pend = pe; m_en = en; m_infl = inf; m_thr = thr;
        m_claim = cl; m_data = dat; m_iack = ia;
        check("mdl_irq", 32'(irq_o), 32'(m_irq));
        check("mdl_iack", 32'(iack_o), 32'(m_iack));
        check("mdl_data", data_o, m_data);
    endtask

    task automatic idle(input int n);
        en_i = 1'b0; we_i = 4'h0; iack_i = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_write(input logic [23:0] addr, input logic [31:0] data);
        en_i = 1'b1; we_i = 4'hF; addr_i = addr; data_i = data;
        step();
        en_i = 1'b0; we_i = 4'h0;
    endtask

    task automatic do_read(input logic [23:0] addr, output logic [31:0] val);
        en_i = 1'b1; we_i = 4'h0; addr_i = addr;
        step();
        val = data_o;
        en_i = 1'b0;
    endtask

    task automatic iack_pulse();
        iack_i = 1'b1;
        step();
        iack_i = 1'b0;
    endtask

    // Asynchronous reset; irq_i is left as the caller set it.
    task automatic do_reset();
        reset_n = 1'b0;
        en_i = 1'b0; we_i = 4'h0; iack_i = 1'b0; addr_i = '0; data_i = '0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_iack", 32'(iack_o), 32'h0);
        check("rst_data", data_o, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [23:0] addr;
        logic [31:0] data;
        logic [N:1]  irq;
        logic        iack;
        logic        exp_irq;
        logic [N:1]  exp_iack;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl [9];

    logic [23:0] rand_addrs [10];

    initial begin
        logic [31:0] v;
        int          k;

        reset_n = 1'b0; irq_i = '0;
        do_reset();
        do_read(24'h002000, v); check("rst_enable_rd", v, 32'h0);
        do_read(24'h200004, v); check("rst_claim_rd", v, 32'h0);

        // Basic flow: configure source 1, pulse it, observe, claim.
        tbl[0] = '{1'b1, 4'hF, 24'h000004, 32'd3,      4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0};
        tbl[1] = '{1'b1, 4'hF, 24'h002000, 32'h2,      4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0};
        tbl[2] = '{1'b1, 4'hF, 24'h200000, 32'h0,      4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0};
        tbl[3] = '{1'b0, 4'h0, 24'h000000, 32'h0,      4'b0001, 1'b0, 1'b0, 4'b0000, 32'h0};
        tbl[4] = '{1'b0, 4'h0, 24'h000000, 32'h0,      4'b0000, 1'b0, 1'b1, 4'b0000, 32'h0};
        tbl[5] = '{1'b1, 4'h0, 24'h001000, 32'h0,      4'b0000, 1'b0, 1'b1, 4'b0000, 32'h2};
        tbl[6] = '{1'b0, 4'h0, 24'h000000, 32'h0,      4'b0000, 1'b1, 1'b1, 4'b0001, 32'h2};
        tbl[7] = '{1'b1, 4'h0, 24'h200004, 32'h0,      4'b0000, 1'b0, 1'b0, 4'b0000, 32'h1};
        tbl[8] = '{1'b1, 4'h0, 24'h001000, 32'h0,      4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0};
        for (int i = 0; i < 9; i++) begin
            en_i = tbl[i].en; we_i = tbl[i].we; addr_i = tbl[i].addr; data_i = tbl[i].data;
            irq_i = tbl[i].irq; iack_i = tbl[i].iack;
            step();
            check($sformatf("vec%0d_irq", i), 32'(irq_o), 32'(tbl[i].exp_irq));
            check($sformatf("vec%0d_iack", i), 32'(iack_o), 32'(tbl[i].exp_iack));
            check($sformatf("vec%0d_data", i), data_o, tbl[i].exp_data);
        end
        idle(1);

        // Threshold masking and release.
        irq_i = '0; do_reset();
        do_write(24'h000004, 32'd2); do_write(24'h002000, 32'h2); do_write(24'h200000, 32'd2);
        irq_i = 4'b0001;
        idle(3);
        check("thr_masked_irq", 32'(irq_o), 32'h0);
        do_write(24'h200000, 32'd1);
        idle(1);
        check("thr_release_irq", 32'(irq_o), 32'h1);
        irq_i = '0;

        // Arbitration: equal priority -> lowest ID, higher priority -> ID 2.
        do_reset();
        do_write(24'h000004, 32'd5); do_write(24'h000008, 32'd5); do_write(24'h002000, 32'h6);
        irq_i = 4'b0011; idle(1); irq_i = '0; idle(1);
        iack_pulse();
        check("arb_tie_iack", 32'(iack_o), 32'h1);
        do_read(24'h200004, v); check("arb_tie_claim", v, 32'h1);
        do_write(24'h200004, 32'd1);
        do_write(24'h000008, 32'd6);
        irq_i = 4'b0001; idle(1); irq_i = '0; idle(1);
        iack_pulse();
        check("arb_prio_iack", 32'(iack_o), 32'h2);
        do_read(24'h200004, v); check("arb_prio_claim", v, 32'h2);

        // In-flight blocking and completion re-raise.
        do_reset();
        do_write(24'h000004, 32'd3); do_write(24'h002000, 32'h2);
        irq_i = 4'b0001; idle(2);
        iack_pulse();
        check("infl_iack", 32'(iack_o), 32'h1);
        idle(3);
        do_read(24'h001000, v); check("infl_pend_blocked", v, 32'h0);
        do_write(24'h200004, 32'd1);
        idle(2);
        check("infl_reraise_irq", 32'(irq_o), 32'h1);
        do_read(24'h001000, v); check("infl_pend_reraise", v, 32'h2);
        irq_i = '0;

        // Disabled source, empty claim, ignored pending write.
        do_reset();
        do_write(24'h000004, 32'd3);
        irq_i = 4'b0001; idle(3);
        check("dis_irq", 32'(irq_o), 32'h0);
        do_read(24'h001000, v); check("dis_pend", v, 32'h2);
        iack_pulse();
        check("empty_iack", 32'(iack_o), 32'h0);
        do_read(24'h200004, v); check("empty_claim", v, 32'h0);
        do_write(24'h001000, 32'h0);
        do_read(24'h001000, v); check("pend_wr_ignored", v, 32'h2);
        irq_i = '0;

        // Reset in the middle of a claim clears in-flight state.
        do_reset();
        do_write(24'h000004, 32'd3); do_write(24'h002000, 32'h2);
        irq_i = 4'b0001; idle(2);
        iack_pulse();
        check("rstmid_iack", 32'(iack_o), 32'h1);
        do_reset();
        idle(1);
        do_read(24'h001000, v); check("rstmid_pend", v, 32'h2);
        do_read(24'h200004, v); check("rstmid_claim", v, 32'h0);
        irq_i = '0;

        // Random traffic against the model.
        rand_addrs = '{24'h000000, 24'h000004, 24'h000008, 24'h00000C, 24'h000010,
                       24'h001000, 24'h002000, 24'h200000, 24'h200004, 24'h003000};
        do_reset();
        for (int i = 0; i < 600; i++) begin
            k = int'($urandom_range(0, 9));
            en_i   = ($urandom_range(0, 2) != 0);
            we_i   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            addr_i = rand_addrs[k] | 24'($urandom_range(0, 3));
            data_i = (k == 8) ? 32'($urandom_range(0, 5)) : $urandom;
            irq_i  = N'($urandom_range(0, 15));
            iack_i = ($urandom_range(0, 3) == 0);
            step();
        end
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
